// File: rtl/serial_arith_pkg.sv
// ---------------------------------------------------------------------------
// serial_arith_pkg
// Shared definitions for the bit-serial arithmetic units.
//   DEFAULT_WIDTH : default operand width for serial units
//   state_t       : control FSM states (IDLE / SHIFT / DONE)
// ---------------------------------------------------------------------------
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_8bit_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_8bit_if
// Request/result bundle for the bit-serial subtractor.
//   i_start, i_a, i_b, i_borrow_in : request, sampled when the unit is free
//   o_busy, o_done                 : status (done is a one-cycle pulse)
//   o_diff, o_borrow_out,
//   o_overflow, o_zero             : registered result and flags
// Modports: slave = subtractor side, master = requester side.
// ---------------------------------------------------------------------------
interface serial_subtractor_8bit_if #(
    parameter int WIDTH = serial_arith_pkg::DEFAULT_WIDTH
);
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_borrow_in;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_diff;
    logic             o_borrow_out;
    logic             o_overflow;
    logic             o_zero;

    modport slave (
        input  i_start, i_a, i_b, i_borrow_in,
        output o_busy, o_done, o_diff, o_borrow_out, o_overflow, o_zero
    );

    modport master (
        output i_start, i_a, i_b, i_borrow_in,
        input  o_busy, o_done, o_diff, o_borrow_out, o_overflow, o_zero
    );
endinterface

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// One-bit full adder cell.
//   i_a, i_b, i_cin : operand bits and carry in
//   o_sum, o_cout   : sum bit and carry out
// ---------------------------------------------------------------------------
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

// File: rtl/serial_subtractor_8bit.sv
// ---------------------------------------------------------------------------
// serial_subtractor_8bit
// Bit-serial two's-complement subtractor: diff = A - B - borrow_in, computed
// LSB first over WIDTH cycles as A + ~B + ~borrow_in using one full adder and
// one carry flip-flop.
//   i_clk   : rising-edge clock
//   i_rst_n : synchronous active-low reset
//   bus     : request/result bundle (slave modport)
// ---------------------------------------------------------------------------
module serial_subtractor_8bit
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    serial_subtractor_8bit_if.slave bus
);
    localparam int              CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
    logic             r_overflow;
    logic             r_zero;

    logic             w_sum;
    logic             w_cout;
    logic             w_accept;
    logic             w_last;
    logic             w_busy;
    logic             w_done;
    logic [WIDTH-1:0] w_res_final;
    logic             w_overflow;

    full_adder u_fa (
        .i_a    (r_a[0]),
        .i_b    (~r_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // A request is taken when idle and also in DONE, so a held start runs
    // operations back-to-back.
    assign w_accept    = bus.i_start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last      = (r_state == SHIFT) && (r_cnt == LAST);
    assign w_res_final = {w_sum, r_res[WIDTH-1:1]};
    // Operand MSBs are kept separately because r_a/r_b are consumed by shifting.
    assign w_overflow  = (r_a_msb ^ r_b_msb) & (w_res_final[WIDTH-1] ^ r_a_msb);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.i_start ? SHIFT : IDLE;
            SHIFT:   w_next = w_last ? DONE : SHIFT;
            DONE:    w_next = bus.i_start ? SHIFT : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            SHIFT:   w_busy = 1'b1;
            DONE:    w_done = 1'b1;
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_res        <= '0;
            r_a_msb      <= 1'b0;
            r_b_msb      <= 1'b0;
            r_carry      <= 1'b0;
            r_cnt        <= '0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_overflow   <= 1'b0;
            r_zero       <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.i_a;
            r_b     <= bus.i_b;
            r_a_msb <= bus.i_a[WIDTH-1];
            r_b_msb <= bus.i_b[WIDTH-1];
            // Subtraction as addition of ~B: the initial carry absorbs the borrow.
            r_carry <= ~bus.i_borrow_in;
            r_res   <= '0;
            r_cnt   <= '0;
        end else if (r_state == SHIFT) begin
            r_res   <= w_res_final;
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_carry <= w_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_diff       <= w_res_final;
                // No final carry from A + ~B + ~bin means A < B + bin.
                r_borrow_out <= ~w_cout;
                r_overflow   <= w_overflow;
                r_zero       <= (w_res_final == '0);
            end
        end
    end

    assign bus.o_busy       = w_busy;
    assign bus.o_done       = w_done;
    assign bus.o_diff       = r_diff;
    assign bus.o_borrow_out = r_borrow_out;
    assign bus.o_overflow   = r_overflow;
    assign bus.o_zero       = r_zero;
endmodule
